// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state encoding for the receiver and transmitter
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous input with a selectable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (!rst_n) {q, meta} <= {RESET_VAL, RESET_VAL};
        else        {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with start-glitch rejection and framing-error pulse
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      UART_RXD,
    output logic [UART_DATA_BITS-1:0] RX_DATA,
    output logic                      RX_DONE,
    output logic                      RX_FRAME_ERR,
    output logic                      RX_BUSY
);
    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    uart_state_t               state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      rxd_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (UART_RXD),
        .q    (rxd_s)
    );

    // Returning to IDLE at mid-stop-bit leaves half a bit to catch a following start edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            RX_DATA      <= '0;
            RX_DONE      <= 1'b0;
            RX_FRAME_ERR <= 1'b0;
            RX_BUSY      <= 1'b0;
        end else begin
            RX_DONE      <= 1'b0;
            RX_FRAME_ERR <= 1'b0;
            cnt          <= cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state   <= START;
                        RX_BUSY <= 1'b1;
                    end
                end
                START: if (cnt == HALF) begin
                    cnt     <= '0;
                    idx     <= '0;
                    state   <= rxd_s ? IDLE : DATA;
                    RX_BUSY <= !rxd_s;
                end
                DATA: if (cnt == LAST) begin
                    cnt        <= '0;
                    shift[idx] <= rxd_s;
                    idx        <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) state <= STOP;
                end
                STOP: if (cnt == LAST) begin
                    cnt          <= '0;
                    state        <= rxd_s ? IDLE : WAIT_HIGH;
                    RX_BUSY      <= !rxd_s;
                    RX_DONE      <= rxd_s;
                    RX_FRAME_ERR <= !rxd_s;
                    if (rxd_s) RX_DATA <= shift;
                end
                WAIT_HIGH: begin
                    cnt <= '0;
                    if (rxd_s) begin
                        state   <= IDLE;
                        RX_BUSY <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: cycle-indexed expectation tables built from frame timing arithmetic, checked every cycle
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int N = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, rx_err, rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .UART_RXD    (rxd),
        .RX_DATA     (rx_data),
        .RX_DONE     (rx_done),
        .RX_FRAME_ERR(rx_err),
        .RX_BUSY     (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] e_data [N];
    bit         e_done [N];
    bit         e_err  [N];
    bit         e_busy [N];
    int         vectors = 0;
    int         miscompares = 0;
    int         done_cyc [$];
    int         err_cyc [$];
    int         done_val [$];

    function automatic int at(input int q[$], input int i);
        return q.size() > i ? q[i] : -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic busy_set(input int a, input int b);
        for (int k = a; k <= b && k < N; k++) e_busy[k] = 1'b1;
    endtask

    task automatic data_from(input int a, input logic [7:0] v);
        for (int k = a; k < N; k++) e_data[k] = v;
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // L is the clock edge that first captures the falling start edge
    task automatic frame(input logic [7:0] b, input bit stop, input int pa, input int pb,
                         input int low_after, output int L);
        L = cyc + 1;
        if (stop) begin
            busy_set(L + 2, L + 153);
            e_done[L + 154] = 1'b1;
            data_from(L + 154, b);
        end else begin
            busy_set(L + 2, L + 5 * (pa + pb) + low_after + 1);
            e_err[L + 154] = 1'b1;
        end
        hold(1'b0, pa);
        for (int i = 0; i < 8; i++) hold(b[i], (i % 2 == 0) ? pb : pa);
        hold(stop, pb);
        if (!stop) hold(1'b0, low_after);
        rxd = 1'b1;
    endtask

    initial begin
        int L, P;
        for (int k = 0; k < N; k++) e_data[k] = 8'h00;
        fork
            forever begin
                @(negedge clk);
                if (cyc >= 1 && cyc < N) begin
                    vectors++;
                    if ({rx_data, rx_done, rx_err, rx_busy} !==
                        {e_data[cyc], e_done[cyc], e_err[cyc], e_busy[cyc]}) begin
                        miscompares++;
                        $display("FAIL cycle %0d: data=%h done=%b err=%b busy=%b, model data=%h done=%b err=%b busy=%b",
                                 cyc, rx_data, rx_done, rx_err, rx_busy,
                                 e_data[cyc], e_done[cyc], e_err[cyc], e_busy[cyc]);
                    end
                    if (rx_done === 1'b1) begin
                        done_cyc.push_back(cyc);
                        done_val.push_back(int'(rx_data));
                    end
                    if (rx_err === 1'b1) err_cyc.push_back(cyc);
                end
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(1'b1, 20);

        frame(8'hA5, 1'b1, CPB, CPB, 0, L);
        hold(1'b1, 20);
        check("t1_latency", at(done_cyc, 0) - L, 154);
        check("t1_data", at(done_val, 0), 'hA5);
        check("t1_pulses", done_cyc.size(), 1);

        L = cyc + 1;
        busy_set(L + 2, L + 9);
        hold(1'b0, 4);
        hold(1'b1, 30);
        check("t2_data", int'(rx_data), 'hA5);
        check("t2_no_done", done_cyc.size(), 1);

        frame(8'h3C, 1'b0, CPB, CPB, 40, L);
        hold(1'b1, 30);
        check("t3_err_latency", at(err_cyc, 0) - L, 154);
        check("t3_err_pulses", err_cyc.size(), 1);
        check("t3_data_kept", int'(rx_data), 'hA5);
        check("t3_no_done", done_cyc.size(), 1);
        frame(8'h11, 1'b1, CPB, CPB, 0, L);
        hold(1'b1, 20);
        check("t3_data_11", int'(rx_data), 'h11);

        frame(8'h00, 1'b1, CPB, CPB, 0, L);
        frame(8'hFF, 1'b1, CPB, CPB, 0, L);
        frame(8'h81, 1'b1, CPB, CPB, 0, L);
        hold(1'b1, 20);
        check("t4_count", done_cyc.size(), 5);
        check("t4_gap_a", at(done_cyc, 3) - at(done_cyc, 2), 160);
        check("t4_gap_b", at(done_cyc, 4) - at(done_cyc, 3), 160);
        check("t4_first", at(done_val, 2), 'h00);
        check("t4_second", at(done_val, 3), 'hFF);
        check("t4_third", at(done_val, 4), 'h81);

        L = cyc + 1;
        P = L + 72;
        busy_set(L + 2, P - 1);
        data_from(P, 8'h00);
        hold(1'b0, 4 * CPB);
        hold(1'b1, 8);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("t5_data_reset", int'(rx_data), 0);
        check("t5_busy_reset", int'(rx_busy), 0);
        hold(1'b1, 30);
        check("t5_no_pulse", done_cyc.size() + err_cyc.size(), 6);
        frame(8'h55, 1'b1, CPB, CPB, 0, L);
        hold(1'b1, 20);
        check("t5_data_55", int'(rx_data), 'h55);

        frame(8'hC3, 1'b1, 15, 17, 0, L);
        hold(1'b1, 10);
        check("t6_data_c3", at(done_val, 6), 'hC3);
        check("t6_latency", at(done_cyc, 6) - L, 154);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
